preproc_axil_regs: RTL and testbench

AXI4-Lite slave register file for the preprocessing core, and the responder side of the testbench's AXI-Lite master agent. It decodes the 5-bit register offsets into read-only identification registers and read/write control registers. It drives the static control outputs (FIFO enable, source select, FIR select) into the datapath in the AXI clock domain. It sits at base 0x4000_0000 on the PS interconnect.

---
 rtl/preproc_regs_pkg.sv | 19 +
 rtl/preproc_axil_regs.sv | 198 +++++++++++++++++++
 tb/tb_preproc_axil_regs.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/preproc_regs_pkg.sv
// Shared register offsets, AXI response codes and FSM state types for the
// preprocessing core's AXI4-Lite register file.
package preproc_regs_pkg;

    localparam logic [4:0] CORE_ID_OFS    = 5'h00;
    localparam logic [4:0] DATE_OFS       = 5'h04;
    localparam logic [4:0] FIFO_EN_OFS    = 5'h08;
    localparam logic [4:0] SEL_SOURCE_OFS = 5'h0C;
    localparam logic [4:0] SEL_FIR_OFS    = 5'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AXI_CLK_PERIOD_NS = 10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/preproc_axil_regs.sv
// AXI4-Lite register file: RO identification words plus RW control fields
// driven as registered static controls into the datapath.
module preproc_axil_regs
    import preproc_regs_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 7,
    parameter logic [31:0] CORE_ID    = 32'hC0DE_0001,
    parameter logic [31:0] DATE       = 32'h2023_0101,
    parameter int          SRC_SEL_W  = 2,
    parameter int          FIR_SEL_W  = 2
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      fifo_en_o,
    output logic [SRC_SEL_W-1:0]      sel_source_o,
    output logic [FIR_SEL_W-1:0]      sel_fir_o
);

    wr_state_t             wst_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_lat_q, w_lat_q;
    logic [4:0]            aw_ofs_q;
    logic                  aw_hi0_q;
    logic [7:0]            w_data_q;
    logic                  w_strb0_q;

    rd_state_t             rst_q;
    logic                  arready_q, rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  fifo_q;
    logic [SRC_SEL_W-1:0]  src_q;
    logic [FIR_SEL_W-1:0]  fir_q;
    logic                  fifo_out_q;
    logic [SRC_SEL_W-1:0]  src_out_q;
    logic [FIR_SEL_W-1:0]  fir_out_q;

    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;
    logic                  unused_bits;

    // Only byte lane 0 and address bits [4:2] carry meaning here.
    assign unused_bits = ^{s_axi_wdata[DATA_WIDTH-1:8], s_axi_wstrb[DATA_WIDTH/8-1:1],
                           s_axi_awaddr[1:0], s_axi_araddr[1:0], w_data_q};

    assign wr_ok = aw_hi0_q && (aw_ofs_q == FIFO_EN_OFS || aw_ofs_q == SEL_SOURCE_OFS ||
                                aw_ofs_q == SEL_FIR_OFS);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wst_q      <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            aw_ofs_q   <= '0;
            aw_hi0_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb0_q  <= 1'b0;
            fifo_q     <= 1'b0;
            src_q      <= '0;
            fir_q      <= '0;
            fifo_out_q <= 1'b0;
            src_out_q  <= '0;
            fir_out_q  <= '0;
        end else begin
            fifo_out_q <= fifo_q;
            src_out_q  <= src_q;
            fir_out_q  <= fir_q;
            case (wst_q)
                W_IDLE: begin
                    if (aw_lat_q && w_lat_q) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        if (wr_ok && w_strb0_q) begin
                            case (aw_ofs_q)
                                FIFO_EN_OFS:    fifo_q <= w_data_q[0];
                                SEL_SOURCE_OFS: src_q  <= w_data_q[SRC_SEL_W-1:0];
                                SEL_FIR_OFS:    fir_q  <= w_data_q[FIR_SEL_W-1:0];
                                default: ;
                            endcase
                        end
                        wst_q <= W_RESP;
                    end else begin
                        // Each channel latches on its own; ready drops once its beat is held.
                        if (s_axi_awvalid && awready_q) begin
                            aw_lat_q <= 1'b1;
                            aw_ofs_q <= {s_axi_awaddr[4:2], 2'b00};
                            aw_hi0_q <= (s_axi_awaddr[ADDR_WIDTH-1:5] == '0);
                        end
                        if (s_axi_wvalid && wready_q) begin
                            w_lat_q   <= 1'b1;
                            w_data_q  <= s_axi_wdata[7:0];
                            w_strb0_q <= s_axi_wstrb[0];
                        end
                        awready_q <= !(aw_lat_q || (s_axi_awvalid && awready_q));
                        wready_q  <= !(w_lat_q || (s_axi_wvalid && wready_q));
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_lat_q  <= 1'b0;
                        w_lat_q   <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wst_q     <= W_IDLE;
                    end
                end
                default: wst_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (s_axi_araddr[ADDR_WIDTH-1:5] == '0) begin
            rd_resp = RESP_OKAY;
            case ({s_axi_araddr[4:2], 2'b00})
                CORE_ID_OFS:    rd_data = CORE_ID;
                DATE_OFS:       rd_data = DATE;
                FIFO_EN_OFS:    rd_data = {{(DATA_WIDTH-1){1'b0}}, fifo_q};
                SEL_SOURCE_OFS: rd_data = {{(DATA_WIDTH-SRC_SEL_W){1'b0}}, src_q};
                SEL_FIR_OFS:    rd_data = {{(DATA_WIDTH-FIR_SEL_W){1'b0}}, fir_q};
                default:        rd_resp = RESP_SLVERR;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rst_q     <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rst_q)
                R_IDLE: begin
                    if (s_axi_arvalid && arready_q) begin
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_resp;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rst_q     <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rst_q     <= R_IDLE;
                    end
                end
                default: rst_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign fifo_en_o     = fifo_out_q;
    assign sel_source_o  = src_out_q;
    assign sel_fir_o     = fir_out_q;

endmodule

// File: tb/tb_preproc_axil_regs.sv
// Self-checking bench for preproc_axil_regs: vector table plus hand-written
// latency, backpressure and mid-transaction reset sequences.
module tb_preproc_axil_regs;
    import preproc_regs_pkg::*;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [6:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, fifo_en;
    logic [1:0]  bresp, rresp, sel_src, sel_fir;
    logic [31:0] rdata;

    always #(AXI_CLK_PERIOD_NS/2) clk = ~clk;

    preproc_axil_regs dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rstn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .fifo_en_o(fifo_en), .sel_source_o(sel_src), .sel_fir_o(sel_fir)
    );

    typedef struct {
        bit          is_wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  resp;
        logic [31:0] rdat;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the later handshake.
    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, input logic [1:0] exp);
        bq.push_back(exp);
        fork
            begin
                int n = 0;
                repeat (aw_dly) @(negedge clk);
                awvalid = 1'b1; awaddr = a;
                while (!awready && n < TMO) begin @(negedge clk); n++; end
                chk("aw_timeout", 32'(n == TMO), 0);
                @(negedge clk); awvalid = 1'b0;
            end
            begin
                int n = 0;
                repeat (w_dly) @(negedge clk);
                wvalid = 1'b1; wdata = d; wstrb = s;
                while (!wready && n < TMO) begin @(negedge clk); n++; end
                chk("w_timeout", 32'(n == TMO), 0);
                @(negedge clk); wvalid = 1'b0;
            end
        join
    endtask

    task automatic bchk(input int hold);
        int n = 0;
        logic [1:0] e;
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        chk("b_timeout", 32'(n == TMO), 0);
        e = bq.pop_front();
        chk("bresp", 32'(bresp), 32'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("b_hold{bvalid,awready,wready}", 32'({bvalid, awready, wready}), 32'b100);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clr", 32'(bvalid), 0);
    endtask

    task automatic rd(input logic [6:0] a, input logic [1:0] er, input logic [31:0] ed);
        int n = 0;
        logic [33:0] e;
        rq.push_back({er, ed});
        arvalid = 1'b1; araddr = a;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        chk("ar_timeout", 32'(n == TMO), 0);
        @(negedge clk);
        arvalid = 1'b0;
        chk($sformatf("rvalid_lat@%h", a), 32'(rvalid), 1);
        e = rq.pop_front();
        chk($sformatf("rresp@%h", a), 32'(rresp), 32'(e[33:32]));
        chk($sformatf("rdata@%h", a), rdata, e[31:0]);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_clr", 32'(rvalid), 0);
    endtask

    function automatic vec_t mk(bit w, logic [6:0] a, logic [31:0] d, logic [3:0] s,
                                int awd, int wd, logic [1:0] r, logic [31:0] rdt);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s;
        v.aw_dly = awd; v.w_dly = wd; v.resp = r; v.rdat = rdt;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, RESP_OKAY,   32'hC0DE_0001));
        tbl.push_back(mk(0, 7'h04, 0, 0, 0, 0, RESP_OKAY,   32'h2023_0101));
        tbl.push_back(mk(0, 7'h08, 0, 0, 0, 0, RESP_OKAY,   32'h0));
        tbl.push_back(mk(1, 7'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_SLVERR, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, RESP_OKAY,   32'hC0DE_0001));
        tbl.push_back(mk(0, 7'h14, 0, 0, 0, 0, RESP_SLVERR, 32'h0));
        tbl.push_back(mk(0, 7'h1C, 0, 0, 0, 0, RESP_SLVERR, 32'h0));
        tbl.push_back(mk(1, 7'h10, 32'h2, 4'hE, 0, 1, RESP_OKAY, 0));
        tbl.push_back(mk(0, 7'h10, 0, 0, 0, 0, RESP_OKAY,   32'h0));
        tbl.push_back(mk(1, 7'h10, 32'h1, 4'h1, 2, 0, RESP_OKAY, 0));
        tbl.push_back(mk(0, 7'h10, 0, 0, 0, 0, RESP_OKAY,   32'h1));
        tbl.push_back(mk(1, 7'h50, 32'h3, 4'hF, 0, 0, RESP_SLVERR, 0));
        tbl.push_back(mk(0, 7'h10, 0, 0, 0, 0, RESP_OKAY,   32'h1));
        tbl.push_back(mk(0, 7'h50, 0, 0, 0, 0, RESP_SLVERR, 32'h0));
        tbl.push_back(mk(1, 7'h0C, 32'h3, 4'h0, 0, 0, RESP_OKAY, 0));
        tbl.push_back(mk(0, 7'h0C, 0, 0, 0, 0, RESP_OKAY,   32'h0));
        tbl.push_back(mk(1, 7'h08, 32'hFFFF_FFFF, 4'hF, 1, 0, RESP_OKAY, 0));
        tbl.push_back(mk(0, 7'h08, 0, 0, 0, 0, RESP_OKAY,   32'h1));
        tbl.push_back(mk(1, 7'h14, 32'h5, 4'hF, 0, 0, RESP_SLVERR, 0));
        tbl.push_back(mk(1, 7'h08, 32'h0, 4'hF, 0, 0, RESP_OKAY, 0));
        tbl.push_back(mk(0, 7'h08, 0, 0, 0, 0, RESP_OKAY,   32'h0));

        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'({awready, wready, arready}), 0);
        chk("rst_valid", 32'({bvalid, rvalid}), 0);
        chk("rst_resp", 32'({bresp, rresp}), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ctrl", 32'({fifo_en, sel_src, sel_fir}), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'({awready, wready, arready}), 32'b111);

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly, tbl[i].resp);
                bchk(0);
            end else begin
                rd(tbl[i].addr, tbl[i].resp, tbl[i].rdat);
            end
        end
        chk("ctrl_after_tbl", 32'({fifo_en, sel_src, sel_fir}), 32'b0_00_01);

        // AW two cycles ahead of W: output moves exactly two cycles after the W handshake.
        wr(7'h0C, 32'h3, 4'hF, 0, 2, RESP_OKAY);
        chk("lat_bvalid_c0", 32'(bvalid), 0);
        chk("lat_src_c0", 32'(sel_src), 0);
        @(negedge clk);
        chk("lat_bvalid_c1", 32'(bvalid), 1);
        chk("lat_src_c1", 32'(sel_src), 0);
        @(negedge clk);
        chk("lat_src_c2", 32'(sel_src), 32'h3);
        bchk(0);
        rd(7'h0C, RESP_OKAY, 32'h3);

        // Same-cycle AW/W with bready held off.
        wr(7'h08, 32'h1, 4'hF, 0, 0, RESP_OKAY);
        bchk(5);
        chk("fifo_en_set", 32'(fifo_en), 1);

        wr(7'h08, 32'h0, 4'hF, 0, 0, RESP_OKAY);
        bchk(0);

        // Reset pulse while a write response is pending.
        wr(7'h08, 32'h1, 4'hF, 0, 0, RESP_OKAY);
        @(negedge clk);
        chk("pre_rst_bvalid", 32'(bvalid), 1);
        @(negedge clk);
        chk("pre_rst_fifo_en", 32'(fifo_en), 1);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_bvalid", 32'(bvalid), 0);
        chk("async_rst_fifo_en", 32'(fifo_en), 0);
        chk("async_rst_awready", 32'(awready), 0);
        void'(bq.pop_front());
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd(7'h08, RESP_OKAY, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
